// File: rtl/sc_point_matrix_datapath.sv
// rtl/sc_point_matrix_datapath.sv - frog position datapath driven by the movement state machine strobes
// Holds row/col, a registered one-hot display matrix, move counter and goal flags.
module sc_point_matrix_datapath #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int START_COL = 3
) (
  input  logic                   SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                   SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                   clear_InLow,
  input  logic                   load0_InLow,
  input  logic                   load1_InLow,
  input  logic [1:0]             shiftselection_In,
  output logic [ROWS*COLS-1:0]   matrix_Out,
  output logic [2:0]             row_Out,
  output logic [2:0]             col_Out,
  output logic                   firstreg_OutLow,
  output logic                   goal_Out,
  output logic                   goalPulse_Out,
  output logic [7:0]             moveCount_Out
);

  localparam logic [2:0] ROW_LAST    = 3'(ROWS - 1);
  localparam logic [2:0] ROW_PRELAST = 3'(ROWS - 2);
  localparam logic [2:0] COL_LAST    = 3'(COLS - 1);
  localparam logic [2:0] COL_START   = 3'(START_COL);
  localparam logic [ROWS*COLS-1:0] MAT_RESET = {{(ROWS*COLS-1){1'b0}}, 1'b1} << START_COL;

  logic [2:0]           row_q, row_d;
  logic [2:0]           col_q, col_d;
  logic [7:0]           count_q, count_d;
  logic                 pulse_q, pulse_d;
  logic [ROWS*COLS-1:0] mat_q, mat_d;
  logic                 moved;
  logic                 clr;

  // One command per cycle, clear > up > down > shift; moves saturate at the edges.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    moved = 1'b0;
    clr   = 1'b0;
    if (!clear_InLow) begin
      row_d = 3'd0;
      col_d = COL_START;
      clr   = 1'b1;
    end else if (!load0_InLow) begin
      if (row_q != ROW_LAST) begin
        row_d = row_q + 3'd1;
        moved = 1'b1;
      end
    end else if (!load1_InLow) begin
      if (row_q != 3'd0) begin
        row_d = row_q - 3'd1;
        moved = 1'b1;
      end
    end else if (shiftselection_In == 2'b01) begin
      if (col_q != COL_LAST) begin
        col_d = col_q + 3'd1;
        moved = 1'b1;
      end
    end else if (shiftselection_In == 2'b10) begin
      if (col_q != 3'd0) begin
        col_d = col_q - 3'd1;
        moved = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = 8'd0;
    else if (moved && (count_q != 8'hFF))
      count_d = count_q + 8'd1;
  end

  assign pulse_d = (row_q == ROW_PRELAST) && (row_d == ROW_LAST);

  // Matrix is decoded from the next position so it never lags row/col.
  always_comb begin
    mat_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        mat_d[r*COLS + c] = (row_d == 3'(r)) && (col_d == 3'(c));
      end
    end
  end

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      row_q   <= 3'd0;
      col_q   <= COL_START;
      count_q <= 8'd0;
      pulse_q <= 1'b0;
      mat_q   <= MAT_RESET;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
      mat_q   <= mat_d;
    end
  end

  assign matrix_Out      = mat_q;
  assign row_Out         = row_q;
  assign col_Out         = col_q;
  assign firstreg_OutLow = (row_q != 3'd0);
  assign goal_Out        = (row_q == ROW_LAST);
  assign goalPulse_Out   = pulse_q;
  assign moveCount_Out   = count_q;

endmodule

// File: tb/tb_sc_point_matrix_datapath.sv
// tb/tb_sc_point_matrix_datapath.sv - scoreboard bench for sc_point_matrix_datapath
module tb_sc_point_matrix_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_n = 1'b1;
  logic        load0_n = 1'b1;
  logic        load1_n = 1'b1;
  logic [1:0]  shsel   = 2'b11;
  logic [63:0] matrix;
  logic [2:0]  row, col;
  logic        firstreg_n, goal, goal_pulse;
  logic [7:0]  count;

  sc_point_matrix_datapath #(.ROWS(8), .COLS(8), .START_COL(3)) dut (
    .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
    .clear_InLow                       (clear_n),
    .load0_InLow                       (load0_n),
    .load1_InLow                       (load1_n),
    .shiftselection_In                 (shsel),
    .matrix_Out                        (matrix),
    .row_Out                           (row),
    .col_Out                           (col),
    .firstreg_OutLow                   (firstreg_n),
    .goal_Out                          (goal),
    .goalPulse_Out                     (goal_pulse),
    .moveCount_Out                     (count)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          row;
    int          col;
    int          cnt;
    logic        pulse;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int   m_row = 0;
  int   m_col = 3;
  int   m_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag, input exp_t e);
    logic [63:0] m;
    m = 64'd0;
    m[e.row*8 + e.col] = 1'b1;
    check_eq({tag, ".row"},   64'(row),        64'(e.row));
    check_eq({tag, ".col"},   64'(col),        64'(e.col));
    check_eq({tag, ".mat"},   matrix,          m);
    check_eq({tag, ".first"}, 64'(firstreg_n), 64'(e.row != 0));
    check_eq({tag, ".goal"},  64'(goal),       64'(e.row == 7));
    check_eq({tag, ".pulse"}, 64'(goal_pulse), 64'(e.pulse));
    check_eq({tag, ".cnt"},   64'(count),      64'(e.cnt));
  endtask

  // Drive one cycle of strobes, push the model's prediction, compare after the edge.
  task automatic step(input string tag, input logic c, input logic u, input logic d, input logic [1:0] s);
    exp_t e;
    int   prev_row;
    bit   mv;
    @(negedge clk);
    clear_n = c; load0_n = u; load1_n = d; shsel = s;
    prev_row = m_row;
    mv = 0;
    if (!c) begin
      m_row = 0; m_col = 3; m_cnt = 0;
    end else if (!u) begin
      if (m_row < 7) begin m_row++; mv = 1; end
    end else if (!d) begin
      if (m_row > 0) begin m_row--; mv = 1; end
    end else if (s == 2'b01) begin
      if (m_col < 7) begin m_col++; mv = 1; end
    end else if (s == 2'b10) begin
      if (m_col > 0) begin m_col--; mv = 1; end
    end
    if (mv && m_cnt < 255) m_cnt++;
    e.row = m_row; e.col = m_col; e.cnt = m_cnt;
    e.pulse = (prev_row == 6) && (m_row == 7);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check_eq({tag, ".sb_empty"}, 64'd1, 64'd0);
    else check_state(tag, exp_q.pop_front());
  endtask

  task automatic idle_inputs();
    clear_n = 1'b1; load0_n = 1'b1; load1_n = 1'b1; shsel = 2'b11;
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    m_row = 0; m_col = 3; m_cnt = 0;
    e.row = 0; e.col = 3; e.cnt = 0; e.pulse = 1'b0;
    check_state("reset", e);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // 1: reset state
    do_reset();
    check_eq("t1.matrix_const", matrix, 64'h0000_0000_0000_0008);
    step("t1.idle", 1, 1, 1, 2'b11);

    // 2: climb to goal and one beyond
    for (int i = 0; i < 8; i++) begin
      step($sformatf("t2.up%0d", i), 1, 0, 1, 2'b11);
      idle_inputs();
    end
    step("t2.idle", 1, 1, 1, 2'b11);

    // 3: down at bottom, left to edge, right to edge
    do_reset();
    step("t3.down0", 1, 1, 0, 2'b11);
    for (int i = 0; i < 5; i++) step($sformatf("t3.left%0d", i), 1, 1, 1, 2'b01);
    for (int i = 0; i < 9; i++) step($sformatf("t3.right%0d", i), 1, 1, 1, 2'b10);
    check_eq("t3.final_cnt", 64'(count), 64'd11);

    // 4: priority
    do_reset();
    step("t4.up_vs_left", 1, 0, 1, 2'b01);
    step("t4.clear_vs_up", 0, 0, 1, 2'b11);

    // 5: alternating up/down saturates the counter
    step("t5.clear", 0, 1, 1, 2'b11);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) step($sformatf("t5.up%0d", i), 1, 0, 1, 2'b11);
      else            step($sformatf("t5.dn%0d", i), 1, 1, 0, 2'b11);
    end
    check_eq("t5.sat", 64'(count), 64'd255);

    // 6: asynchronous reset while load0 is held
    step("t6.up", 1, 0, 1, 2'b11);
    step("t6.left", 1, 1, 1, 2'b01);
    @(negedge clk);
    load0_n = 1'b0;
    @(posedge clk);
    m_row++; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    #5;
    rst = 1'b1;
    #1;
    e.row = 0; e.col = 3; e.cnt = 0; e.pulse = 1'b0;
    check_state("t6.async", e);
    @(posedge clk);
    #1;
    check_state("t6.held", e);
    @(negedge clk);
    rst = 1'b0;
    m_row = 0; m_col = 3; m_cnt = 0;
    @(posedge clk);
    #1;
    e.row = 1; e.col = 3; e.cnt = 1; e.pulse = 1'b0;
    check_state("t6.release", e);
    m_row = 1; m_cnt = 1;
    @(negedge clk);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_point_matrix_datapath.md
Name: sc_point_matrix_datapath

Overview:
- Datapath that executes the active-low command strobes issued by the frog-movement state machine: clear, move-up (load0), move-down (load1) and left/right shift-selection.
- Holds the frog position as a one-hot ROWS x COLS matrix for the display path.
- Returns the first-row feedback flag that gates the state machine's down move.
- Also tracks move count and goal arrival.

Parameters:
ROWS, 8, number of lanes (row 0 = bottom/start lane, row ROWS-1 = goal lane)
COLS, 8, columns per lane (column 0 = rightmost, COLS-1 = leftmost)
START_COL, 3, column loaded on reset/clear (must be < COLS)

Ports:
SC_STATEMACHINEPOINT_CLOCK_50  in  1  system clock, 50 MHz
SC_STATEMACHINEPOINT_RESET_InHigh  in  1  asynchronous, active-high reset
clear_InLow  in  1  0 = return frog to start
load0_InLow  in  1  0 = move up one row
load1_InLow  in  1  0 = move down one row
shiftselection_In  in  2  01 = move left, 10 = move right, 00/11 = hold
matrix_Out  out  ROWS*COLS  one-hot position; row r at bits [r*COLS +: COLS]
row_Out  out  3  current row index
col_Out  out  3  current column index
firstreg_OutLow  out  1  0 when frog is in row 0
goal_Out  out  1  1 while frog is in row ROWS-1
goalPulse_Out  out  1  one-cycle pulse on entry to row ROWS-1
moveCount_Out  out  8  accepted moves since last clear, saturating

Behaviour:
- Clock and reset: clock SC_STATEMACHINEPOINT_CLOCK_50; reset SC_STATEMACHINEPOINT_RESET_InHigh, asynchronous, active-high.
- Reset values:
  - row = 0, col = START_COL.
  - matrix_Out has only bit START_COL set.
  - firstreg_OutLow = 0, goal_Out = 0, goalPulse_Out = 0, moveCount_Out = 0.
- Reset mid-move: overrides any command in the same cycle.
- State: registered row and col. matrix_Out is registered and decoded from the next row/col, so it is always exactly one-hot and consistent with row_Out/col_Out.
- Command sampling: commands are level-sampled on every rising edge, with no edge detection. The upstream state machine asserts each command for exactly one cycle.
- Latency: all outputs update on the same edge that samples the command (1 cycle after command asserted).
- Command priority when several are asserted in one cycle (only one command is executed per cycle):
  1. clear
  2. load0
  3. load1
  4. shiftselection
- clear: row = 0, col = START_COL, moveCount = 0, goalPulse = 0.
- load0 (up):
  - If row < ROWS-1: row + 1, and the move counts.
  - If row == ROWS-1: position held; not counted; no pulse.
- load1 (down):
  - If row > 0: row - 1, and the move counts.
  - If row == 0: held; not counted.
  - The state machine also gates down moves using firstreg_OutLow; this block saturates regardless.
- shiftselection 01 (left):
  - If col < COLS-1: col + 1, and the move counts.
  - Otherwise held, no wrap.
- shiftselection 10 (right):
  - If col > 0: col - 1, and the move counts.
  - Otherwise held, no wrap.
- shiftselection 00 or 11: hold.
- moveCount_Out:
  - Increments by 1 only on moves that change position.
  - Saturates at 255 with no wrap.
  - Cleared only by reset or clear.
- firstreg_OutLow: combinational from registered row; 0 iff row == 0.
- goal_Out: combinational; 1 iff row == ROWS-1.
- goalPulse_Out: registered. High for exactly one cycle on the edge where row transitions from ROWS-2 to ROWS-1; 0 otherwise.
- Idle (all strobes 1, shiftselection 11): every register holds.

Test Plan:
1. Reset asserted then released, no commands -> matrix_Out = 64'h0000_0000_0000_0008, row 0, col 3, firstreg_OutLow = 0, moveCount 0.
2. Seven single-cycle load0 pulses, then an eighth -> row 1..7 in turn; goalPulse_Out high for 1 cycle after pulse 7; eighth pulse: row stays 7, count stays 7, no pulse.
3. From reset, load1 pulse; shiftselection 01 x5; then 10 x9 -> down ignored (count 0); col 4,5,6,7,7 (count 4); then right down to col 0, held at 0 (count 11).
4. load0 and shiftselection=01 asserted together, then clear and load0 together -> first cycle: row 1, col 3 (up wins); second: row 0, col 3, count 0 (clear wins).
5. 300 alternating up/down moves starting at row 0 -> moveCount_Out saturates at 255 and stays; firstreg_OutLow toggles 1/0 with row.
6. Reset asserted asynchronously mid-cycle while load0 = 0 -> outputs return to reset values immediately, without waiting for a clock edge; the held load0 is not executed until reset is released.
